// File: rtl/dh_pkg.sv
// Shared types and constants for the Diffie-Hellman peer responder.
// Holds the controller state encoding, key width and default sizes.
package dh_pkg;

  localparam int KEY_W    = 128;
  localparam int DH_WIDTH = 64;
  localparam int DH_EXP_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PUB_EXP,
    WAIT_PEER,
    KEY_EXP,
    DONE,
    ERR
  } dh_state_t;

endpackage

// File: rtl/dh_mod_mul.sv
// Sequential interleaved modular multiplier: res = a*b mod p.
// Ports: clk, rst_n, go (load a/b), a, b, p, res, done (1-cycle pulse).
// Latency is fixed at WIDTH+1 cycles: one load, then WIDTH iterations.
module dh_mod_mul
  import dh_pkg::*;
#(
  parameter int WIDTH = DH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] res,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH+1:0] acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             done_q;

  logic [WIDTH+1:0] pe;
  logic [WIDTH+1:0] t0;
  logic [WIDTH+1:0] t1;
  logic [WIDTH+1:0] t2;

  // acc < p, so 2*acc + a < 3p: two conditional subtracts suffice.
  always_comb begin
    pe = {2'b00, p};
    t0 = (acc_q << 1) + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    t1 = (t0 >= pe) ? (t0 - pe) : t0;
    t2 = (t1 >= pe) ? (t1 - pe) : t1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (go) begin
      acc_q  <= '0;
      a_q    <= a;
      b_q    <= b;
      cnt_q  <= CW'(WIDTH);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      acc_q  <= t2;
      b_q    <= {b_q[WIDTH-2:0], 1'b0};
      cnt_q  <= cnt_q - CW'(1);
      run_q  <= (cnt_q != CW'(1));
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign res  = acc_q[WIDTH-1:0];
  assign done = done_q;

endmodule

// File: rtl/dh_peer_responder.sv
// Alice-side DH block: A = g^a mod p, then K = B^a mod p from the peer.
// Ports: start/priv_key/modulus/generator in; busy, pub_key/pub_valid out;
// peer_pub/peer_valid/peer_ready handshake; enc_key/key_valid/key_err out.
// Macro DH_PUB_CHECK_EN enables peer key range checking (key_err).
module dh_peer_responder
  import dh_pkg::*;
#(
  parameter int WIDTH = DH_WIDTH,
  parameter int EXP_W = DH_EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EXP_W-1:0] priv_key,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] generator,
  output logic             busy,
  output logic [KEY_W-1:0] pub_key,
  output logic             pub_valid,
  input  logic [KEY_W-1:0] peer_pub,
  input  logic             peer_valid,
  output logic             peer_ready,
  output logic [KEY_W-1:0] enc_key,
  output logic             key_valid,
  output logic             key_err
);

  localparam int BW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  dh_state_t        state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             sqr_q, sqr_d;
  logic             kick_q, kick_d;
  logic             fin_q, fin_d;
  logic [WIDTH-1:0] pub_q, pub_d;
  logic             pubv_q, pubv_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             keyv_q, keyv_d;
  logic             err_q, err_d;

  logic             go;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_res;
  logic             mul_done;
  logic [WIDTH-1:0] r_nxt;
  logic             bad;

  dh_mod_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go),
    .a    (mul_a),
    .b    (mul_b),
    .p    (p_q),
    .res  (mul_res),
    .done (mul_done)
  );

`ifdef DH_PUB_CHECK_EN
  // Reject 0, 1, p-1 and anything non-reduced or with upper bits set.
  assign bad = ((peer_pub >> WIDTH) != '0)
            || (peer_pub[WIDTH-1:0] < WIDTH'(2))
            || (peer_pub[WIDTH-1:0] > (p_q - WIDTH'(2)));
`else
  logic [KEY_W-1:0] unused_hi;
  assign unused_hi = peer_pub >> WIDTH;
  assign bad       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    base_d     = base_q;
    p_d        = p_q;
    e_d        = e_q;
    bit_d      = bit_q;
    sqr_d      = sqr_q;
    kick_d     = 1'b0;
    fin_d      = 1'b0;
    pub_d      = pub_q;
    pubv_d     = pubv_q;
    key_d      = key_q;
    keyv_d     = keyv_q;
    err_d      = err_q;
    go         = 1'b0;
    mul_a      = r_q;
    mul_b      = r_q;
    r_nxt      = r_q;
    peer_ready = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = PUB_EXP;
          e_d     = priv_key;
          p_d     = modulus;
          base_d  = generator;
          r_d     = WIDTH'(1);
          bit_d   = BW'(EXP_W - 1);
          sqr_d   = 1'b1;
          kick_d  = 1'b1;
          pubv_d  = 1'b0;
          keyv_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      PUB_EXP, KEY_EXP: begin
        // Next multiply is launched in the same cycle the previous
        // one completes, so each step costs exactly WIDTH+1 cycles.
        if (kick_q) begin
          go = 1'b1;
        end else if (mul_done) begin
          if (sqr_q) begin
            r_nxt = mul_res;
            r_d   = r_nxt;
            go    = 1'b1;
            mul_a = mul_res;
            mul_b = base_q;
            sqr_d = 1'b0;
          end else begin
            r_nxt = e_q[bit_q] ? mul_res : r_q;
            r_d   = r_nxt;
            if (bit_q == '0) begin
              fin_d = 1'b1;
            end else begin
              bit_d = bit_q - BW'(1);
              go    = 1'b1;
              mul_a = r_nxt;
              mul_b = r_nxt;
              sqr_d = 1'b1;
            end
          end
        end else if (fin_q) begin
          if (state_q == PUB_EXP) begin
            pub_d   = r_q;
            pubv_d  = 1'b1;
            state_d = WAIT_PEER;
          end else begin
            key_d   = r_q;
            keyv_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WAIT_PEER: begin
        peer_ready = 1'b1;
        if (peer_valid) begin
          if (bad) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            state_d = KEY_EXP;
            base_d  = peer_pub[WIDTH-1:0];
            r_d     = WIDTH'(1);
            bit_d   = BW'(EXP_W - 1);
            sqr_d   = 1'b1;
            kick_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      base_q  <= '0;
      p_q     <= '0;
      e_q     <= '0;
      bit_q   <= '0;
      sqr_q   <= 1'b0;
      kick_q  <= 1'b0;
      fin_q   <= 1'b0;
      pub_q   <= '0;
      pubv_q  <= 1'b0;
      key_q   <= '0;
      keyv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      base_q  <= base_d;
      p_q     <= p_d;
      e_q     <= e_d;
      bit_q   <= bit_d;
      sqr_q   <= sqr_d;
      kick_q  <= kick_d;
      fin_q   <= fin_d;
      pub_q   <= pub_d;
      pubv_q  <= pubv_d;
      key_q   <= key_d;
      keyv_q  <= keyv_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == PUB_EXP) || (state_q == WAIT_PEER)
                  || (state_q == KEY_EXP);
  assign pub_key   = KEY_W'(pub_q);
  assign pub_valid = pubv_q;
  assign enc_key   = KEY_W'(key_q);
  assign key_valid = keyv_q;
  assign key_err   = err_q;

endmodule

// File: tb/tb_dh_peer_responder.sv
// Scoreboard bench for dh_peer_responder (WIDTH=64, EXP_W=8).
// Expected keys are pushed on stimulus and popped on output edges.
module tb_dh_peer_responder;

  localparam int LAT = 2 * 8 * 65 + 2;
  localparam int K_PUB = 0;
  localparam int K_KEY = 1;
  localparam int K_ERR = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   priv_key = '0;
  logic [63:0]  modulus = '0;
  logic [63:0]  generator = '0;
  logic         busy;
  logic [127:0] pub_key;
  logic         pub_valid;
  logic [127:0] peer_pub = '0;
  logic         peer_valid = 1'b0;
  logic         peer_ready;
  logic [127:0] enc_key;
  logic         key_valid;
  logic         key_err;

  dh_peer_responder #(
    .WIDTH(64),
    .EXP_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .priv_key  (priv_key),
    .modulus   (modulus),
    .generator (generator),
    .busy      (busy),
    .pub_key   (pub_key),
    .pub_valid (pub_valid),
    .peer_pub  (peer_pub),
    .peer_valid(peer_valid),
    .peer_ready(peer_ready),
    .enc_key   (enc_key),
    .key_valid (key_valid),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    logic [127:0] val;
    int           t0;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic pv_prev = 1'b0;
  logic kv_prev = 1'b0;
  logic ke_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mexp(input logic [127:0] b,
                                        input logic [7:0] e,
                                        input logic [127:0] p);
    logic [255:0] r;
    logic [255:0] bb;
    r  = 256'd1;
    bb = {128'd0, b} % {128'd0, p};
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * bb) % {128'd0, p};
      bb = (bb * bb) % {128'd0, p};
    end
    return r[127:0];
  endfunction

  task automatic pop_chk(input int kind, input logic [127:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 128'(exp_q.size()), 128'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", 128'(kind), 128'(e.kind));
      chk("sb_val", got, e.val);
      chk("sb_lat", 128'(cyc - e.t0), 128'(e.lat));
      if (kind == K_KEY) chk("key_no_err", 128'(key_err), 128'd0);
      if (kind == K_ERR) chk("err_no_key", 128'(key_valid), 128'd0);
    end
  endtask

  always @(negedge clk) begin
    if (pub_valid && !pv_prev) pop_chk(K_PUB, pub_key);
    if (key_valid && !kv_prev) pop_chk(K_KEY, enc_key);
    if (key_err && !ke_prev) pop_chk(K_ERR, 128'd0);
    pv_prev = pub_valid;
    kv_prev = key_valid;
    ke_prev = key_err;
  end

  task automatic do_start(input logic [7:0] a, input logic [63:0] p,
                          input logic [63:0] g);
    exp_t e;
    priv_key  = a;
    modulus   = p;
    generator = g;
    start     = 1'b1;
    e.kind = K_PUB;
    e.val  = mexp({64'd0, g}, a, {64'd0, p});
    e.t0   = cyc + 1;
    e.lat  = LAT;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 128'(busy), 128'd1);
    chk("start_clr_pv", 128'(pub_valid), 128'd0);
    chk("start_clr_kv", 128'(key_valid), 128'd0);
    chk("start_clr_ke", 128'(key_err), 128'd0);
  endtask

  task automatic wait_pub();
    int n = 0;
    while (!(pub_valid && peer_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pub_wait", 128'(pub_valid && peer_ready), 128'd1);
  endtask

  task automatic do_peer(input logic [127:0] b, input int kind,
                         input logic [127:0] val);
    exp_t e;
    peer_pub   = b;
    peer_valid = 1'b1;
    e.kind = kind;
    e.val  = val;
    e.t0   = cyc + 1;
    e.lat  = (kind == K_ERR) ? 0 : LAT;
    exp_q.push_back(e);
    @(negedge clk);
    peer_valid = 1'b0;
    chk("ready_drop", 128'(peer_ready), 128'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [63:0] p,
                          input logic [63:0] g, input logic [127:0] b);
    do_start(a, p, g);
    wait_pub();
    do_peer(b, K_KEY, mexp(b, a, {64'd0, p}));
    drain();
  endtask

  initial begin
    logic [127:0] pr;
    logic [127:0] gr;
    logic [127:0] br;
    logic [7:0]   ar;

    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_pub", pub_key, 128'd0);
    chk("rst_pv", 128'(pub_valid), 128'd0);
    chk("rst_ready", 128'(peer_ready), 128'd0);
    chk("rst_key", enc_key, 128'd0);
    chk("rst_kv", 128'(key_valid), 128'd0);
    chk("rst_ke", 128'(key_err), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Early peer_valid and a restart during PUB_EXP must be ignored.
    do_start(8'd15, 64'd67, 64'd2);
    repeat (50) @(negedge clk);
    peer_pub   = 128'd32;
    peer_valid = 1'b1;
    priv_key   = 8'd3;
    start      = 1'b1;
    #1;
    chk("ready_in_exp", 128'(peer_ready), 128'd0);
    @(negedge clk);
    start      = 1'b0;
    peer_valid = 1'b0;
    priv_key   = 8'd15;
    chk("busy_hold", 128'(busy), 128'd1);
    chk("pv_hold", 128'(pub_valid), 128'd0);
    wait_pub();
    chk("pub_5", pub_key, 128'd5);
    do_peer(128'd32, K_KEY, 128'd43);
    drain();
    chk("done_idle", 128'(busy), 128'd0);
    chk("done_pv", 128'(pub_valid), 128'd1);
    peer_valid = 1'b1;
    #1;
    chk("ready_in_done", 128'(peer_ready), 128'd0);
    @(negedge clk);
    peer_valid = 1'b0;
    chk("done_key_43", enc_key, 128'd43);

    run_pair(8'd15, 64'd67, 64'd2, 128'd64);
    chk("key_14", enc_key, 128'd14);

    run_pair(8'd0, 64'd67, 64'd2, 128'd32);
    chk("zero_key", enc_key, 128'd1);
    chk("zero_pub", pub_key, 128'd1);

`ifdef DH_PUB_CHECK_EN
    pr = 128'd1;
    for (int i = 0; i < 3; i++) begin
      br = (i == 0) ? 128'd66 : (i == 1) ? 128'd1 : (pr << 100) | 128'd5;
      do_start(8'd15, 64'd67, 64'd2);
      wait_pub();
      do_peer(br, K_ERR, 128'd0);
      drain();
      chk("err_flag", 128'(key_err), 128'd1);
      chk("err_kv", 128'(key_valid), 128'd0);
      chk("err_idle", 128'(busy), 128'd0);
    end
`else
    run_pair(8'd15, 64'd67, 64'd2, 128'd66);
    chk("nochk_66", enc_key, 128'd66);
    run_pair(8'd15, 64'd67, 64'd2, 128'd1);
    chk("nochk_1", enc_key, 128'd1);
`endif

    pr = 128'h7FFF_FFFF_FFFF_FFC5;
    for (int i = 0; i < 2; i++) begin
      gr = ({64'd0, $urandom, $urandom} % (pr - 128'd2)) + 128'd2;
      br = ({64'd0, $urandom, $urandom} % (pr - 128'd3)) + 128'd2;
      ar = 8'($urandom_range(1, 255));
      run_pair(ar, pr[63:0], gr[63:0], br);
    end

    // Asynchronous reset in the middle of KEY_EXP.
    do_start(8'd15, 64'd67, 64'd2);
    wait_pub();
    do_peer(128'd32, K_KEY, 128'd43);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_pub", pub_key, 128'd0);
    chk("mid_rst_pv", 128'(pub_valid), 128'd0);
    chk("mid_rst_key", enc_key, 128'd0);
    chk("mid_rst_kv", 128'(key_valid), 128'd0);
    chk("mid_rst_rdy", 128'(peer_ready), 128'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 128'(busy), 128'd0);
    do_start(8'd15, 64'd67, 64'd2);
    wait_pub();
    chk("post_rst_pub", pub_key, 128'd5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
